// File: rtl/axi_w_order_m3.sv
// Write-order tracker: FIFO of one-hot AW winners whose head drives the W-channel grant.
// Optional W_ORDER_BYPASS_EN: zero-latency grant on a push into an empty FIFO.
module axi_w_order_m3 #(
  parameter int NUM_MASTER = 3,
  parameter int DEPTH      = 4,
  parameter int WIDTH_CNT  = $clog2(DEPTH + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [NUM_MASTER-1:0] AW_VALID,
  input  logic [NUM_MASTER-1:0] AW_READY,
  input  logic                  S_WVALID,
  input  logic                  S_WREADY,
  input  logic                  S_WLAST,
  output logic [NUM_MASTER-1:0] w_order_grant,
  output logic                  aw_stall,
  output logic [WIDTH_CNT-1:0]  order_cnt,
  output logic                  order_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_MASTER-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH_CNT-1:0]  count_q, count_d;
  logic                  err_q, err_d;

  logic [NUM_MASTER-1:0] push_vec;
  logic                  push_onehot, push_multi, wlast_hs;
  logic                  empty, full, push_ok, pop;

  assign push_vec    = AW_VALID & AW_READY;
  assign push_onehot = $onehot(push_vec);
  assign push_multi  = (push_vec != '0) && !push_onehot;
  assign wlast_hs    = S_WVALID & S_WREADY & S_WLAST;
  assign empty       = (count_q == '0);
  assign full        = (count_q == WIDTH_CNT'(DEPTH));

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop      = 1'b0;
    push_ok  = 1'b0;
    err_d    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

`ifdef W_ORDER_BYPASS_EN
    // A WLAST on the bypassed grant retires the entry in the same cycle it is written.
    pop = wlast_hs && (!empty || push_onehot);
`else
    pop = wlast_hs && !empty;
`endif
    push_ok = push_onehot && (!full || pop);

    err_d = push_multi || (push_onehot && !push_ok) || (wlast_hs && !pop);

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + WIDTH_CNT'(1);
      2'b01:   count_d = count_q - WIDTH_CNT'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      // NOTE: the order storage is tiny and a stale one-hot must never reach the mux, so it is cleared on reset like any flop.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_vec;
    end
  end

  always_comb begin
    w_order_grant = empty ? '0 : mem_q[rd_ptr_q];
`ifdef W_ORDER_BYPASS_EN
    if (empty && push_onehot) w_order_grant = push_vec;
`endif
  end

  assign aw_stall  = full;
  assign order_cnt = count_q;
  assign order_err = err_q;

endmodule

// File: tb/tb_axi_w_order_m3.sv
// Directed self-checking bench for axi_w_order_m3 (default build, DEPTH=4, three masters).
// Inputs change #1 after a rising edge; outputs are checked at that same point, before new inputs are applied.
module tb_axi_w_order_m3;

  logic       ACLK;
  logic       ARESETn;
  logic [2:0] AW_VALID, AW_READY;
  logic       S_WVALID, S_WREADY, S_WLAST;
  logic [2:0] w_order_grant;
  logic       aw_stall;
  logic [2:0] order_cnt;
  logic       order_err;

  int n_cmp = 0;
  int n_bad = 0;

  axi_w_order_m3 #(.NUM_MASTER(3), .DEPTH(4)) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .AW_VALID      (AW_VALID),
    .AW_READY      (AW_READY),
    .S_WVALID      (S_WVALID),
    .S_WREADY      (S_WREADY),
    .S_WLAST       (S_WLAST),
    .w_order_grant (w_order_grant),
    .aw_stall      (aw_stall),
    .order_cnt     (order_cnt),
    .order_err     (order_err)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic aw(input logic [2:0] v, input logic [2:0] r);
    AW_VALID = v;
    AW_READY = r;
  endtask

  task automatic w(input logic v, input logic r, input logic l);
    S_WVALID = v;
    S_WREADY = r;
    S_WLAST  = l;
  endtask

  task automatic expect_state(input string tag, input int g, input int c, input int s, input int e);
    check({tag, ".grant"}, w_order_grant, g);
    check({tag, ".cnt"},   order_cnt,     c);
    check({tag, ".stall"}, aw_stall,      s);
    check({tag, ".err"},   order_err,     e);
  endtask

  initial begin
    ARESETn = 1'b0;
    aw(3'b000, 3'b000);
    w(1'b0, 1'b0, 1'b0);
    step();
    step();
    expect_state("reset", 0, 0, 0, 0);
    ARESETn = 1'b1;
    step();
    expect_state("idle", 0, 0, 0, 0);

    // In-order grants: AW from M1, M2, M0, then three single-beat bursts.
    aw(3'b010, 3'b010); step(); expect_state("push_m1", 3'b010, 1, 0, 0);
    aw(3'b100, 3'b100); step(); expect_state("push_m2", 3'b010, 2, 0, 0);
    aw(3'b001, 3'b001); step(); expect_state("push_m0", 3'b010, 3, 0, 0);
    aw(3'b000, 3'b000);
    w(1'b1, 1'b1, 1'b1);
    step(); expect_state("pop1", 3'b100, 2, 0, 0);
    step(); expect_state("pop2", 3'b001, 1, 0, 0);
    step(); expect_state("pop3", 3'b000, 0, 0, 0);
    w(1'b0, 1'b0, 1'b0);
    step(); expect_state("drained", 0, 0, 0, 0);

    // Fill to DEPTH with M0, then overflow, then push+pop while full.
    aw(3'b001, 3'b001);
    for (int i = 0; i < 4; i++) step();
    expect_state("full", 3'b001, 4, 1, 0);
    step(); expect_state("overflow", 3'b001, 4, 1, 1);
    aw(3'b000, 3'b000);
    step(); expect_state("overflow_clr", 3'b001, 4, 1, 0);
    aw(3'b010, 3'b010);
    w(1'b1, 1'b1, 1'b1);
    step(); expect_state("full_push_pop", 3'b001, 4, 1, 0);
    aw(3'b000, 3'b000);
    step(); expect_state("full_pop_a", 3'b001, 3, 0, 0);
    step(); expect_state("full_pop_b", 3'b001, 2, 0, 0);
    step(); expect_state("wrap_head", 3'b010, 1, 0, 0);
    step(); expect_state("wrap_empty", 3'b000, 0, 0, 0);
    w(1'b0, 1'b0, 1'b0);

    // Four-beat burst from M2 with WLAST only on the last beat; beat 2 stalls.
    aw(3'b100, 3'b100); step();
    aw(3'b000, 3'b000);
    expect_state("burst_aw", 3'b100, 1, 0, 0);
    w(1'b1, 1'b1, 1'b0); step(); check("beat1.grant", w_order_grant, 3'b100);
    w(1'b1, 1'b0, 1'b1); step(); check("stall.grant", w_order_grant, 3'b100);
    check("stall.cnt", order_cnt, 1);
    w(1'b1, 1'b1, 1'b0); step(); check("beat2.grant", w_order_grant, 3'b100);
    w(1'b1, 1'b1, 1'b0); step(); check("beat3.grant", w_order_grant, 3'b100);
    w(1'b1, 1'b1, 1'b1);
    check("beat4.grant", w_order_grant, 3'b100);
    step(); expect_state("burst_done", 3'b000, 0, 0, 0);
    w(1'b0, 1'b0, 1'b0);

    // Multi-hot push, masking by AW_READY, and WLAST with nothing outstanding.
    aw(3'b011, 3'b111); step(); expect_state("multi_push", 0, 0, 0, 1);
    aw(3'b111, 3'b010); step(); expect_state("masked_push", 3'b010, 1, 0, 0);
    aw(3'b000, 3'b000);
    w(1'b1, 1'b1, 1'b1); step(); expect_state("masked_pop", 0, 0, 0, 0);
    step(); expect_state("pop_empty", 0, 0, 0, 1);
    w(1'b0, 1'b0, 1'b0);
    step(); expect_state("pop_empty_clr", 0, 0, 0, 0);

    // Reset mid-burst with two entries outstanding, then normal operation.
    aw(3'b001, 3'b001); step();
    aw(3'b100, 3'b100); step();
    aw(3'b000, 3'b000);
    expect_state("pre_rst", 3'b001, 2, 0, 0);
    w(1'b1, 1'b1, 1'b0);
    ARESETn = 1'b0;
    step(); expect_state("mid_rst", 0, 0, 0, 0);
    ARESETn = 1'b1;
    w(1'b0, 1'b0, 1'b0);
    aw(3'b010, 3'b010); step(); expect_state("post_rst", 3'b010, 1, 0, 0);
    aw(3'b000, 3'b000);
    w(1'b1, 1'b1, 1'b1); step(); expect_state("post_rst_pop", 0, 0, 0, 0);
    w(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
